// File: rtl/mult_pkg.sv
// Shared definitions for the multiply sequencer and the ALU control that drives it.
package mult_pkg;

  localparam int         WIDTH_DEF = 32;
  localparam logic [5:0] MUL_CODE  = 6'b011001;
  localparam logic [5:0] OUT_CODE  = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/mult_sign_unit.sv
// Signed-multiply support: operand magnitudes, result sign, and final product negation.
module mult_sign_unit #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_signed,
  input  logic [WIDTH-1:0]   i_opA,
  input  logic [WIDTH-1:0]   i_opB,
  output logic [WIDTH-1:0]   o_magA,
  output logic [WIDTH-1:0]   o_magB,
  output logic               o_neg,
  input  logic               i_neg,
  input  logic [2*WIDTH-1:0] i_prod,
  output logic [2*WIDTH-1:0] o_prod
);
  import mult_pkg::*;

  logic w_negA;
  logic w_negB;

  assign w_negA = i_is_signed & i_opA[WIDTH-1];
  assign w_negB = i_is_signed & i_opB[WIDTH-1];

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign o_magA = w_negA ? -i_opA : i_opA;
  assign o_magB = w_negB ? -i_opB : i_opB;
  assign o_neg  = w_negA ^ w_negB;

  assign o_prod = i_neg ? -i_prod : i_prod;

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: loads magnitudes, runs WIDTH iterations,
// then captures the sign-corrected product into HI/LO.
module mult_ctrl #(
  parameter int         WIDTH    = mult_pkg::WIDTH_DEF,
  parameter logic [5:0] MUL_CODE = mult_pkg::MUL_CODE,
  parameter logic [5:0] OUT_CODE = mult_pkg::OUT_CODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   mul_dataA,
  output logic [WIDTH-1:0]   mul_dataB,
  output logic [5:0]         mul_signal,
  input  logic [2*WIDTH-1:0] mul_dataOut
);
  import mult_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_dataA;
  logic [WIDTH-1:0]   r_dataB;
  logic [5:0]         r_signal;

  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;

  mult_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .i_is_signed (is_signed),
    .i_opA       (opA),
    .i_opB       (opB),
    .o_magA      (w_magA),
    .o_magB      (w_magB),
    .o_neg       (w_neg),
    .i_neg       (r_neg),
    .i_prod      (mul_dataOut),
    .o_prod      (w_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dataA  <= '0;
      r_dataB  <= '0;
      r_signal <= OUT_CODE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_dataA <= w_magA;
            r_dataB <= w_magB;
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        // Operands have been stable for a cycle; the multiplier latches them on the code change.
        S_LOAD: begin
          r_signal <= MUL_CODE;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_signal <= OUT_CODE;
            r_state  <= S_FIX;
          end
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_prod;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= S_DONE;
        end
        default: begin
          r_signal <= OUT_CODE;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign mul_dataA  = r_dataA;
  assign mul_dataB  = r_dataB;
  assign mul_signal = r_signal;

endmodule
